// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: controller state encoding
// and the width of the single adder slice that is reused every cycle.
package digit_serial_adder_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_serial_adder_rca4.sv
// 4-bit ripple-carry adder slice: s = a + b + ci, co = carry out of bit 3.
module digit_serial_adder_rca4
  import digit_serial_adder_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co
);

  logic ripple_s;

  // Ripple the carry through the four full-adder bit positions.
  always_comb begin
    s        = '0;
    ripple_s = ci;
    for (int i = 0; i < DIGIT_W; i++) begin
      s[i]     = a[i] ^ b[i] ^ ripple_s;
      ripple_s = (a[i] & b[i]) | (ripple_s & (a[i] ^ b[i]));
    end
    co = ripple_s;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: one 4-bit slice is sequenced over WIDTH/4 cycles,
// least-significant nibble first, with the inter-digit carry held in a
// register. Valid/ready handshakes on the operand and result sides.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

  if ((WIDTH < DIGIT_W) || ((WIDTH % DIGIT_W) != 0)) begin : g_width_check
    $error("digit_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t state_r;
  state_t state_nxt_s;

  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   sum_sh_r;
  logic [WIDTH-1:0]   sum_nxt_s;
  logic               carry_r;
  logic               sa_r;
  logic               sb_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               last_s;

  logic [DIGIT_W-1:0] nib_s;
  logic               nib_co_s;

  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;

  // The only adder in the datapath; fed by the low nibbles of the shifters.
  digit_serial_adder_rca4 u_rca4 (
    .a  (a_sh_r[DIGIT_W-1:0]),
    .b  (b_sh_r[DIGIT_W-1:0]),
    .ci (carry_r),
    .s  (nib_s),
    .co (nib_co_s)
  );

  assign last_s = (cnt_r == CNT_LAST);

  // Partial sum after this cycle's nibble enters from the top.
  always_comb begin
    sum_nxt_s = sum_sh_r >> DIGIT_W;
    sum_nxt_s[WIDTH-1 -: DIGIT_W] = nib_s;
  end

  // Next-state logic: accept in IDLE, count digits in RUN, wait for consumer in DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with handshake/status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == ST_IDLE);
      out_valid_r <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s == ST_RUN);
    end
  end

  // Operand shifters, carry, digit counter and the result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r   <= '0;
      b_sh_r   <= '0;
      sum_sh_r <= '0;
      carry_r  <= 1'b0;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      cnt_r    <= '0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            carry_r <= cin;
            sa_r    <= a[WIDTH-1];
            sb_r    <= b[WIDTH-1];
            cnt_r   <= '0;
          end
        end
        ST_RUN: begin
          a_sh_r   <= a_sh_r >> DIGIT_W;
          b_sh_r   <= b_sh_r >> DIGIT_W;
          sum_sh_r <= sum_nxt_s;
          carry_r  <= nib_co_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          // Result registers load only on the final digit so they stay
          // stable outside DONE and across backpressure.
          if (last_s) begin
            sum_r  <= sum_nxt_s;
            cout_r <= nib_co_s;
            ovf_r  <= (sa_r == sb_r) && (sum_nxt_s[WIDTH-1] != sa_r);
          end
        end
        ST_DONE: begin
          sum_r <= sum_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;

endmodule
